m_timer: RTL

- Memory-mapped timer/counter peripheral on the P7 system bridge.
- Its interrupt output drives HWInt[0] of the CP0 block.
- CPU programs it with sw/lw through the bridge.
- Supports one-shot and auto-reload modes.
- CP0 samples the interrupt level each cycle and gates it with SR.IM/IE/EXL.

---
 rtl/timer_pkg.sv | 35 +++
 rtl/m_timer_if.sv | 10 +
 rtl/timer_prescaler.sv | 27 ++
 rtl/m_timer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared encodings for the m_timer peripheral: FSM states, register map, mode values and CTRL bit layout.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESET   = 2'd1;
    localparam logic [1:0] ADDR_COUNT    = 2'd2;
    localparam logic [1:0] ADDR_PRESCALE = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam int PRESCALE_W = 8;

    function automatic logic [31:0] ctrl_word(input logic en, input logic [1:0] mode, input logic im);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT] = en;
        w[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
        w[CTRL_IM_BIT] = im;
        return w;
    endfunction

endpackage

// File: rtl/m_timer_if.sv
// Bridge-side register bus of the timer: word address, write strobe/data and combinational read data.
interface m_timer_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_prescaler.sv
// Count-rate divider for m_timer; only built when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
    import timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] reload,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] div_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= '0;
        end else if (clear) begin
            div_reg <= '0;
        end else if (run) begin
            div_reg <= (div_reg == '0) ? reload : div_reg - PRESCALE_W'(1);
        end
    end

    assign tick = (div_reg == '0);
endmodule
`endif

// File: rtl/m_timer.sv
// Memory-mapped one-shot / auto-reload timer driving CP0 HWInt[0].
// Optional PRESCALE register and divider enabled by TIMER_PRESCALE_EN.
module m_timer
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    m_timer_if.slave   bus,
    output logic       irq
);
    state_t           state_reg;
    logic             en_reg;
    logic [1:0]       mode_reg;
    logic             im_reg;
    logic             irq_flag_reg;
    logic [CNT_W-1:0] preset_reg;
    logic [CNT_W-1:0] count_reg;
    logic             tick;

    logic ctrl_wr;
    logic preset_wr;

    assign ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
    assign preset_wr = bus.we && (bus.addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_reg <= '0;
        end else if (bus.we && (bus.addr == ADDR_PRESCALE)) begin
            prescale_reg <= bus.wdata[PRESCALE_W-1:0];
        end
    end

    timer_prescaler u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_reg == S_LOAD),
        .run    ((state_reg == S_CNT) && en_reg),
        .reload (prescale_reg),
        .tick   (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            en_reg       <= 1'b0;
            mode_reg     <= MODE_ONESHOT;
            im_reg       <= 1'b0;
            irq_flag_reg <= 1'b0;
            preset_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (preset_wr) begin
                preset_reg <= bus.wdata[CNT_W-1:0];
            end

            case (state_reg)
                S_IDLE: begin
                    if (en_reg) begin
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Clearing here ends the single-cycle reload-mode pulse.
                    count_reg    <= preset_reg;
                    irq_flag_reg <= 1'b0;
                    state_reg    <= S_CNT;
                end
                S_CNT: begin
                    if (!en_reg) begin
                        state_reg <= S_IDLE;
                    end else if (tick) begin
                        if (count_reg == '0) begin
                            state_reg <= S_INT;
                        end else begin
                            count_reg <= count_reg - CNT_W'(1);
                        end
                    end
                end
                S_INT: begin
                    irq_flag_reg <= 1'b1;
                    if (mode_reg == MODE_RELOAD) begin
                        state_reg <= S_LOAD;
                    end else begin
                        en_reg    <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // A CTRL write overrides the FSM's EN clear and its flag set in the same cycle.
            if (ctrl_wr) begin
                en_reg       <= bus.wdata[CTRL_EN_BIT];
                mode_reg     <= bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
                im_reg       <= bus.wdata[CTRL_IM_BIT];
                irq_flag_reg <= 1'b0;
            end
        end
    end

    assign irq = irq_flag_reg & im_reg;

    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            ADDR_CTRL:     bus.rdata = ctrl_word(en_reg, mode_reg, im_reg);
            ADDR_PRESET:   bus.rdata = 32'(preset_reg);
            ADDR_COUNT:    bus.rdata = 32'(count_reg);
`ifdef TIMER_PRESCALE_EN
            ADDR_PRESCALE: bus.rdata = 32'(prescale_reg);
`else
            ADDR_PRESCALE: bus.rdata = '0;
`endif
            default:       bus.rdata = '0;
        endcase
    end
endmodule
